// File: rtl/ldm_stm_sequencer_if.sv
// Signal bundle between the ARM block-transfer sequencer and its control unit,
// register file and memory port.
interface ldm_stm_sequencer_if;
   logic        start;
   logic [31:0] IR;
   logic [31:0] base;
   logic        MOC;
   logic [31:0] mem_rdata;
   logic [31:0] rf_rdata;
   logic        MOV;
   logic        RW;
   logic [31:0] addr;
   logic [31:0] mem_wdata;
   logic [3:0]  reg_sel;
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;
   logic        pc_load;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, IR, base, MOC, mem_rdata, rf_rdata,
      input  MOV, RW, addr, mem_wdata, reg_sel, rf_we, rf_wdata,
             wb_en, wb_reg, wb_data, pc_load, busy, done, err
   );

   modport slave (
      input  start, IR, base, MOC, mem_rdata, rf_rdata,
      output MOV, RW, addr, mem_wdata, reg_sel, rf_we, rf_wdata,
             wb_en, wb_reg, wb_data, pc_load, busy, done, err
   );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM (addressing mode 4) sequencer: walks the register list lowest-first,
// runs one MOV/MOC memory handshake per register and produces base writeback.
module ldm_stm_sequencer #(
   parameter int MOC_TIMEOUT = 16
) (
   input logic                Clk,
   input logic                Clr,
   ldm_stm_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, SETUP, SCAN, REQ, WRLD, WB, FIN} state_t;

   localparam logic [7:0] TIMER_LAST = 8'(MOC_TIMEOUT - 1);

   state_t      state, state_next;
   logic        p_q, u_q, w_q, l_q, rn_in_list_q;
   logic [3:0]  rn_q, sel_q;
   logic [15:0] list_q;
   logic [31:0] base_q, addr_q, final_q, rdata_q;
   logic [7:0]  timer_q;
   logic        pc_loaded_q, err_q;

   logic [4:0]  n;
   logic [31:0] n4, start_addr;
   logic [3:0]  lowest;
   logic [15:0] list_after;
   logic        moc_hit, timeout;
   logic        unused_ir;

   assign unused_ir = ^{bus.IR[31:25], bus.IR[22]};

   always_comb begin
      n      = '0;
      lowest = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, list_q[i]};
      for (int i = 15; i >= 0; i--) if (list_q[i]) lowest = 4'(i);
   end

   assign n4         = {25'd0, n, 2'b00};
   assign list_after = list_q & ~(16'd1 << sel_q);
   assign moc_hit    = (state == REQ) && bus.MOC;
   // MOC in the final allowed cycle still wins over the timeout.
   assign timeout    = (state == REQ) && !bus.MOC && (timer_q == TIMER_LAST);

   always_comb begin
      case ({p_q, u_q})
         2'b01:   start_addr = base_q;
         2'b11:   start_addr = base_q + 32'd4;
         2'b00:   start_addr = base_q - n4 + 32'd4;
         default: start_addr = base_q - n4;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next   = state;
      bus.MOV      = 1'b0;
      bus.RW       = 1'b0;
      bus.rf_we    = 1'b0;
      bus.wb_en    = 1'b0;
      bus.done     = 1'b0;
      bus.pc_load  = 1'b0;
      bus.busy     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_next = SETUP;
         end
         SETUP: begin
            bus.busy   = 1'b1;
            state_next = (n == 5'd0) ? FIN : SCAN;
         end
         SCAN: begin
            bus.busy   = 1'b1;
            state_next = REQ;
         end
         REQ: begin
            bus.busy = 1'b1;
            bus.MOV  = 1'b1;
            bus.RW   = l_q;
            if (moc_hit) begin
               if (l_q)                     state_next = WRLD;
               else if (list_after != '0)   state_next = SCAN;
               else                         state_next = WB;
            end else if (timeout) begin
               state_next = IDLE;
            end
         end
         WRLD: begin
            bus.busy   = 1'b1;
            bus.rf_we  = 1'b1;
            state_next = (list_q != '0) ? SCAN : WB;
         end
         WB: begin
            bus.busy   = 1'b1;
            // A base register reloaded from memory keeps the loaded value.
            bus.wb_en  = w_q && !(l_q && rn_in_list_q);
            state_next = FIN;
         end
         FIN: begin
            bus.done    = 1'b1;
            bus.pc_load = pc_loaded_q;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         p_q          <= 1'b0;
         u_q          <= 1'b0;
         w_q          <= 1'b0;
         l_q          <= 1'b0;
         rn_in_list_q <= 1'b0;
         rn_q         <= '0;
         sel_q        <= '0;
         list_q       <= '0;
         base_q       <= '0;
         addr_q       <= '0;
         final_q      <= '0;
         rdata_q      <= '0;
         timer_q      <= '0;
         pc_loaded_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q <= timeout;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  p_q          <= bus.IR[24];
                  u_q          <= bus.IR[23];
                  w_q          <= bus.IR[21];
                  l_q          <= bus.IR[20];
                  rn_q         <= bus.IR[19:16];
                  list_q       <= bus.IR[15:0];
                  rn_in_list_q <= bus.IR[{1'b0, bus.IR[19:16]}];
                  base_q       <= bus.base;
                  pc_loaded_q  <= 1'b0;
               end
            end
            SETUP: begin
               addr_q  <= start_addr;
               final_q <= u_q ? (base_q + n4) : (base_q - n4);
            end
            SCAN: begin
               sel_q   <= lowest;
               timer_q <= '0;
            end
            REQ: begin
               if (bus.MOC) begin
                  list_q <= list_after;
                  if (l_q) rdata_q <= bus.mem_rdata;
                  else     addr_q  <= addr_q + 32'd4;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            WRLD: begin
               addr_q <= addr_q + 32'd4;
               if (sel_q == 4'd15) pc_loaded_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.err       = err_q;
   assign bus.addr      = addr_q;
   assign bus.reg_sel   = sel_q;
   assign bus.rf_wdata  = rdata_q;
   assign bus.wb_reg    = rn_q;
   assign bus.wb_data   = final_q;
   assign bus.mem_wdata = bus.rf_rdata;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a word-level model of LDM/STM queues
// the expected memory, register-file, writeback and completion events.
module tb_ldm_stm_sequencer;
   localparam int MOC_TIMEOUT = 16;

   logic Clk = 1'b0;
   logic Clr;
   always #5 Clk = ~Clk;

   ldm_stm_sequencer_if bus ();

   ldm_stm_sequencer #(.MOC_TIMEOUT(MOC_TIMEOUT)) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   typedef struct {logic [31:0] addr; logic rw; logic [3:0] rsel; logic [31:0] wdata;} acc_t;
   typedef struct {logic [3:0] rsel; logic [31:0] data;} rfw_t;
   typedef struct {logic [3:0] rn; logic [31:0] data;} wb_t;
   typedef struct {logic is_err; logic pc; int lat;} cmp_t;

   acc_t acc_q[$];
   rfw_t rfw_q[$];
   wb_t  wb_q[$];
   cmp_t cmp_q[$];

   acc_t mon_acc;
   rfw_t mon_rfw;
   wb_t  mon_wb;
   cmp_t mon_cmp;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int pending = 0;
   int acc_seen = 0;
   int mov_run = 0;
   int last_run = 0;
   int moc_delay = -1;
   bit moc_off = 1'b0;
   bit in_req = 1'b0;
   int wait_left = 0;
   logic [31:0] regs [16];

   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   assign bus.rf_rdata = regs[bus.reg_sel];

   always @(posedge Clk) cyc <= cyc + 1;

   // Memory responder: answers each request after a delay and sprinkles stray MOC outside requests.
   always @(posedge Clk) begin
      #1;
      if (bus.MOV && !moc_off) begin
         if (!in_req) begin
            in_req    = 1'b1;
            wait_left = (moc_delay < 0) ? int'($urandom_range(0, 3)) : moc_delay;
         end
         if (wait_left == 0) begin
            bus.MOC       = 1'b1;
            bus.mem_rdata = memval(bus.addr);
         end else begin
            bus.MOC       = 1'b0;
            bus.mem_rdata = $urandom;
            wait_left--;
         end
      end else begin
         in_req        = 1'b0;
         bus.MOC       = moc_off ? 1'b0 : ($urandom_range(0, 3) == 0);
         bus.mem_rdata = $urandom;
      end
   end

   always @(negedge Clk) begin
      if (Clr) begin
         if (bus.MOV) mov_run++;
         else begin
            if (mov_run != 0) last_run = mov_run;
            mov_run = 0;
         end
         if (pending != 0 && cyc == start_cyc + 1) checkOutput("busy_after_start", bus.busy, 1);
         if (bus.MOV && bus.MOC) begin
            acc_seen++;
            checkOutput("access_expected", acc_q.size() != 0, 1);
            if (acc_q.size() != 0) begin
               mon_acc = acc_q.pop_front();
               checkOutput("addr", bus.addr, mon_acc.addr);
               checkOutput("rw", bus.RW, mon_acc.rw);
               checkOutput("reg_sel", bus.reg_sel, mon_acc.rsel);
               if (!mon_acc.rw) checkOutput("mem_wdata", bus.mem_wdata, mon_acc.wdata);
            end
         end
         if (bus.rf_we) begin
            checkOutput("rf_we_expected", rfw_q.size() != 0, 1);
            if (rfw_q.size() != 0) begin
               mon_rfw = rfw_q.pop_front();
               checkOutput("rf_reg", bus.reg_sel, mon_rfw.rsel);
               checkOutput("rf_wdata", bus.rf_wdata, mon_rfw.data);
            end
         end
         if (bus.wb_en) begin
            checkOutput("wb_expected", wb_q.size() != 0, 1);
            if (wb_q.size() != 0) begin
               mon_wb = wb_q.pop_front();
               checkOutput("wb_reg", bus.wb_reg, mon_wb.rn);
               checkOutput("wb_data", bus.wb_data, mon_wb.data);
            end
         end
         if (bus.done || bus.err) begin
            checkOutput("completion_expected", cmp_q.size() != 0, 1);
            if (cmp_q.size() != 0) begin
               mon_cmp = cmp_q.pop_front();
               checkOutput("done_err", {bus.done, bus.err}, mon_cmp.is_err ? 2'b01 : 2'b10);
               checkOutput("pc_load", bus.pc_load, mon_cmp.pc);
               checkOutput("busy_at_end", bus.busy, 0);
               if (mon_cmp.lat >= 0) checkOutput("done_latency", cyc - start_cyc, mon_cmp.lat);
               if (mon_cmp.is_err) checkOutput("mov_cycles", last_run, MOC_TIMEOUT);
               checkOutput("leftover_access", acc_q.size(), 0);
               checkOutput("leftover_rf_we", rfw_q.size(), 0);
               checkOutput("leftover_wb", wb_q.size(), 0);
            end
            pending = 0;
         end
      end
   end

   task automatic flushQueues();
      acc_q.delete();
      rfw_q.delete();
      wb_q.delete();
      cmp_q.delete();
      pending = 0;
   endtask

   // Word-level model: the block is n consecutive words, lowest register at lowest address.
   task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] base);
      logic p, u, w, l;
      logic [3:0] rn;
      logic [15:0] list;
      logic [31:0] first, a;
      int n, k;
      p = ir[24]; u = ir[23]; w = ir[21]; l = ir[20];
      rn = ir[19:16]; list = ir[15:0];
      n = 0;
      for (int i = 0; i < 16; i++) if (list[i]) n++;
      if (moc_off) begin
         cmp_q.push_back('{1'b1, 1'b0, -1});
      end else begin
         if (n > 0) begin
            if (u) first = base + (p ? 32'd4 : 32'd0);
            else   first = (base - (p ? 32'd4 : 32'd0)) - 32'(4 * (n - 1));
            k = 0;
            for (int r = 0; r < 16; r++) begin
               if (list[r]) begin
                  a = first + 32'(4 * k);
                  acc_q.push_back('{a, l, 4'(r), regs[r]});
                  if (l) rfw_q.push_back('{4'(r), memval(a)});
                  k++;
               end
            end
            if (w && !(l && list[rn]))
               wb_q.push_back('{rn, u ? base + 32'(4 * n) : base - 32'(4 * n)});
         end
         cmp_q.push_back('{1'b0, l && list[15] && (n > 0), (n == 0) ? 2 : -1});
      end
      @(posedge Clk); #1;
      start_cyc = cyc;
      pending   = 1;
      bus.start = 1'b1;
      bus.IR    = ir;
      bus.base  = base;
      @(posedge Clk); #1;
      bus.start = 1'b0;
      bus.IR    = $urandom;
      bus.base  = $urandom;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 3000 && pending != 0; i++) begin
         @(posedge Clk); #1;
         bus.start = !moc_off && ($urandom_range(0, 7) == 0);
         bus.IR    = $urandom;
      end
      bus.start = 1'b0;
      if (pending != 0) begin
         checkOutput("completion_timeout", pending, 0);
         flushQueues();
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_MOV", bus.MOV, 0);
      checkOutput("rst_RW", bus.RW, 0);
      checkOutput("rst_addr", bus.addr, 0);
      checkOutput("rst_reg_sel", bus.reg_sel, 0);
      checkOutput("rst_rf_we", bus.rf_we, 0);
      checkOutput("rst_rf_wdata", bus.rf_wdata, 0);
      checkOutput("rst_wb_en", bus.wb_en, 0);
      checkOutput("rst_wb_reg", bus.wb_reg, 0);
      checkOutput("rst_wb_data", bus.wb_data, 0);
      checkOutput("rst_pc_load", bus.pc_load, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_err", bus.err, 0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, regs[0]);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic p, u, w, l;
      logic [3:0] rn;
      logic [15:0] list;
      logic [31:0] base;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      Clr       = 1'b0;
      bus.start = 1'b0;
      bus.IR    = '0;
      bus.base  = '0;
      repeat (3) @(posedge Clk);
      #1;
      checkResetOutputs();
      Clr = 1'b1;

      $display("[TB] LDMIA R0!,{R1,R3,R15}");
      moc_delay = 2;
      applyStimulus(32'hE8B0_800A, 32'h0000_0100);
      waitIdle();

      $display("[TB] STMDB R13!,{R4-R7}");
      moc_delay = -1;
      applyStimulus(32'hE92D_00F0, 32'h0000_0200);
      waitIdle();

      $display("[TB] LDMIB R2!,{R2,R5}");
      applyStimulus(32'hE9B2_0024, 32'h0000_0040);
      waitIdle();

      $display("[TB] STMDA R1,{}");
      applyStimulus(32'hE801_0000, 32'h0000_0080);
      waitIdle();

      $display("[TB] LDMDB wrapping below zero");
      applyStimulus(32'hE930_0007, 32'h0000_0004);
      waitIdle();

      $display("[TB] STMIA with MOC withheld");
      moc_off = 1'b1;
      applyStimulus(32'hE880_0003, 32'h0000_0500);
      waitIdle();
      moc_off = 1'b0;
      applyStimulus(32'hE8A0_0003, 32'h0000_0500);
      waitIdle();

      $display("[TB] reset during second REQ");
      moc_delay = 2;
      acc_seen  = 0;
      applyStimulus(32'hE890_001E, 32'h0000_0300);
      for (int i = 0; i < 200; i++) begin
         if (acc_seen == 1 && bus.MOV) break;
         @(posedge Clk); #1;
      end
      checkOutput("reached_second_req", bus.MOV, 1);
      Clr = 1'b0;
      #1;
      checkResetOutputs();
      flushQueues();
      repeat (2) @(posedge Clk);
      #1;
      Clr = 1'b1;
      moc_delay = -1;
      applyStimulus(32'hE890_001E, 32'h0000_0300);
      waitIdle();

      $display("[TB] randomized transfers");
      for (int t = 0; t < 40; t++) begin
         p  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         l  = 1'($urandom_range(0, 1));
         rn = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0:       list = 16'h0000;
            1, 2:    list = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: list = 16'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) base = 32'($urandom_range(0, 8) * 4);
         else                           base = $urandom & 32'hFFFF_FFFC;
         applyStimulus({4'hE, 3'b100, p, u, 1'b0, w, l, rn, list}, base);
         waitIdle();
      end

      repeat (3) @(posedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle sequencer for ARM Load/Store Multiple (LDMIA/IB/DA/DB, STMIA/IB/DA/DB, addressing mode 4). The control unit pulses start from its block-transfer dispatch state. The block then walks the 16-bit register list, drives the memory address, register-file and memory handshake (MOV/MOC) for each transfer, and computes base writeback. The control unit waits on done/err before fetching the next instruction.

Parameters:
MOC_TIMEOUT, 16, max cycles to wait for MOC per access before abort (2..255)

Ports:
Clk  in  1  system clock, rising edge
Clr  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
IR  in  32  instruction; P=IR[24], U=IR[23], W=IR[21], L=IR[20], Rn=IR[19:16], list=IR[15:0]
base  in  32  value of Rn, sampled with start
MOC  in  1  memory operation complete
mem_rdata  in  32  memory read data, valid when MOC=1
rf_rdata  in  32  register-file read data for reg_sel (stores)
MOV  out  1  memory access request
RW  out  1  1=read (LDM), 0=write (STM); valid while MOV
addr  out  32  memory word address
mem_wdata  out  32  combinational copy of rf_rdata
reg_sel  out  4  register being transferred
rf_we  out  1  one-cycle register-file write strobe (loads)
rf_wdata  out  32  latched mem_rdata
wb_en  out  1  one-cycle base writeback strobe
wb_reg  out  4  = latched Rn
wb_data  out  32  final base value
pc_load  out  1  one-cycle pulse with done when R15 was loaded
busy  out  1  high from cycle after start until done/err
done  out  1  one-cycle completion pulse
err  out  1  one-cycle abort pulse (MOC timeout)

Behaviour:
- Reset (Clr=0, any time, including mid-transfer): state=IDLE; all outputs 0; latched list, count and timer cleared; no partial writeback. Interrupted transfers are not resumed.
- States: IDLE, SETUP, SCAN, REQ, WRLD, WB, FIN.
- IDLE: on start=1, latch IR fields and base, then go to SETUP. start in any other state is ignored.
- SETUP (1 cycle):
  - n = popcount(list), 0..16.
  - Start address: IA: base. IB: base+4. DA: base-4n+4. DB: base-4n.
  - Final base: U=1: base+4n. U=0: base-4n.
  - All arithmetic is mod 2^32.
  - n=0: go to FIN with done=1; no MOV, no wb_en.
- SCAN (1 cycle): reg_sel = index of lowest set bit of the remaining list; go to REQ. Registers always go lowest-first to ascending addresses.
- REQ: MOV=1, RW=L, addr and reg_sel held stable.
  - On MOC=1: clear the bit and deassert MOV next cycle. Load: latch mem_rdata, go to WRLD. Store: addr+=4, go to SCAN if bits remain, else WB.
  - Timer counts REQ cycles. If it reaches MOC_TIMEOUT without MOC: MOV=0, err=1, busy=0, go to IDLE. No wb_en, no done.
- WRLD (1 cycle): rf_we=1 with reg_sel/rf_wdata. Then addr+=4; go to SCAN or WB. Record if reg_sel==15.
- WB (1 cycle): wb_en=1 only if W=1 AND NOT (L=1 AND Rn in list), i.e. a loaded base wins. Go to FIN.
- FIN: done=1 for one cycle, plus pc_load if R15 was loaded; busy=0 in the same cycle; return to IDLE.
- Latency per register: load = 1 + MOC wait + 1 cycles; store = 1 + MOC wait cycles. Fixed overhead is start->SETUP->...->FIN.
- MOC is ignored outside REQ. MOC arriving in the same cycle the timer expires counts as success.

Test Plan:
- LDMIA R0!,{R1,R3,R15} (IR=0xE8B0800A), base=0x100, MOC after 2 cycles -> reads 0x100/0x104/0x108 to R1/R3/R15; wb_en with wb_data=0x10C; pc_load with done.
- STMDB R13!,{R4-R7} (IR=0xE92D00F0), base=0x200 -> writes R4..R7 to 0x1F0,0x1F4,0x1F8,0x1FC; mem_wdata matches rf_rdata; wb_data=0x1F0; no rf_we.
- LDMIB R2!,{R2,R5}, base=0x40 -> reads 0x44 (R2), 0x48 (R5); wb_en stays 0; done=1.
- STMDA R1,{} (empty list) -> done two cycles after start; MOV, rf_we and wb_en never asserted.
- STMIA with MOC held 0, MOC_TIMEOUT=16 -> MOV high exactly 16 cycles; err pulse; no done or wb_en; next start is accepted.
- Clr pulled low during the second REQ of a 4-register LDM -> all outputs 0 immediately; after release the block is IDLE and a fresh LDM runs correctly.
